// File: rtl/pattern_event_log_if.sv
// Bundle of control inputs and status/read-back outputs of pattern_event_log.
// clk and rst stay outside the bundle as plain ports.
interface pattern_event_log_if #(
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) ();
    logic             valid_in;
    logic             det_in;
    logic             rd_en;
    logic             clr;
    logic [TS_W-1:0]  rd_data;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    modport master (
        output valid_in, det_in, rd_en, clr,
        input  rd_data, rd_valid, empty, full, hit_count, drop_count, overflow
    );

    modport slave (
        input  valid_in, det_in, rd_en, clr,
        output rd_data, rd_valid, empty, full, hit_count, drop_count, overflow
    );
endinterface

// File: rtl/pattern_event_log.sv
// Timestamps pattern detections against a count of stream bits and queues them
// in a small FIFO, with saturating hit/drop counters and a sticky overflow flag.
module pattern_event_log #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    pattern_event_log_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [TS_W-1:0]  TS_ONE  = 1;
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [TS_W-1:0]  ts;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [TS_W-1:0]  rd_data_q;
    logic             rd_valid_q;
    logic [CNT_W-1:0] hit_q;
    logic [CNT_W-1:0] drop_q;
    logic             overflow_q;

    logic is_empty;
    logic is_full;
    logic pop;
    logic push_ok;
    logic drop_ev;

    // Extra pointer MSB tells a full ring from an empty one when the indices match.
    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Read handshake: rd_en is a request honoured only while not empty; the popped
    // entry appears on rd_data one cycle later, qualified by a single-cycle rd_valid.
    assign pop     = bus.rd_en && !is_empty;
    assign push_ok = bus.det_in && (!is_full || pop);
    assign drop_ev = bus.det_in && is_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else if (bus.clr) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.valid_in) begin
                ts <= ts + TS_ONE;
            end
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (hit_q != '1) begin
                    hit_q <= hit_q + CNT_ONE;
                end
            end
            if (drop_ev) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + CNT_ONE;
                end
            end
        end
    end

    // Storage is not reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok && !bus.clr) begin
            mem[wr_ptr[AW-1:0]] <= ts;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.hit_count  = hit_q;
    assign bus.drop_count = drop_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_pattern_event_log.sv
// Bench for pattern_event_log: directed scenarios plus random traffic, checked
// against a queue-based reference model; a 4-bit-timestamp copy covers wrap.
module tb_pattern_event_log;
    localparam int DEPTH   = 8;
    localparam int TS_W    = 16;
    localparam int CNT_W   = 16;
    localparam int TS_MOD  = 1 << TS_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_event_log_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();
    pattern_event_log_if #(.TS_W(4),    .CNT_W(CNT_W)) bus4 ();

    assign bus4.valid_in = bus.valid_in;
    assign bus4.det_in   = bus.det_in;
    assign bus4.rd_en    = bus.rd_en;
    assign bus4.clr      = bus.clr;

    pattern_event_log #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    pattern_event_log #(.DEPTH(DEPTH), .TS_W(4), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    // Reference model state
    int              m_ts;
    logic [TS_W-1:0] exp_q[$];
    int              m_hit;
    int              m_drop;
    bit              m_ovf;
    bit              m_rv;
    logic [TS_W-1:0] m_rd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ts = 0;
        exp_q.delete();
        m_hit = 0;
        m_drop = 0;
        m_ovf = 1'b0;
        m_rv = 1'b0;
        m_rd = '0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit r, input bit c);
        bit was_full;
        bit do_pop;
        if (c) begin
            m_ts = 0;
            exp_q.delete();
            m_hit = 0;
            m_drop = 0;
            m_ovf = 1'b0;
            m_rv = 1'b0;
            return;
        end
        was_full = (exp_q.size() == DEPTH);
        do_pop   = r && (exp_q.size() > 0);
        m_rv = do_pop;
        if (do_pop) m_rd = exp_q.pop_front();
        if (d) begin
            if (was_full && !do_pop) begin
                m_ovf = 1'b1;
                if (m_drop < CNT_MAX) m_drop++;
            end else begin
                exp_q.push_back(m_ts[TS_W-1:0]);
                if (m_hit < CNT_MAX) m_hit++;
            end
        end
        if (v) m_ts = (m_ts + 1) % TS_MOD;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rv));
        check({tag, ".rd_data"},  32'(bus.rd_data),  32'(m_rd));
        check({tag, ".empty"},    32'(bus.empty),    32'(exp_q.size() == 0));
        check({tag, ".full"},     32'(bus.full),     32'(exp_q.size() == DEPTH));
        check({tag, ".hit"},      32'(bus.hit_count),  32'(m_hit));
        check({tag, ".drop"},     32'(bus.drop_count), 32'(m_drop));
        check({tag, ".ovf"},      32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic step(input string tag, input bit v, input bit d, input bit r, input bit c);
        @(negedge clk);
        bus.valid_in = v;
        bus.det_in   = d;
        bus.rd_en    = r;
        bus.clr      = c;
        @(posedge clk);
        model_step(v, d, r, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.det_in   = 1'b0;
        bus.rd_en    = 1'b0;
        bus.clr      = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Ten stream bits, one detection, one read: timestamp 10
        for (int i = 0; i < 10; i++) step("ts10", 1, 0, 0, 0);
        step("ts10_det", 0, 1, 0, 0);
        step("ts10_rd", 0, 0, 1, 0);
        check("ts10.data", 32'(bus.rd_data), 32'd10);
        check("ts10.rv", 32'(bus.rd_valid), 32'd1);
        check("ts10.empty", 32'(bus.empty), 32'd1);
        check("ts10.hit", 32'(bus.hit_count), 32'd1);
        step("ts10_idle", 0, 0, 0, 0);
        check("ts10.rv_drop", 32'(bus.rd_valid), 32'd0);

        // Nine detections into an eight-deep FIFO
        step("fill_clr", 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step("fill", 1, 1, 0, 0);
        check("fill.full", 32'(bus.full), 32'd1);
        check("fill.hit", 32'(bus.hit_count), 32'd8);
        check("fill.drop", 32'(bus.drop_count), 32'd1);
        check("fill.ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step("drain", 0, 0, 1, 0);
            check("drain.order", 32'(bus.rd_data), 32'(i));
        end
        step("drain_empty_rd", 0, 0, 1, 0);
        check("drain.ovf_sticky", 32'(bus.overflow), 32'd1);

        // Simultaneous push and pop while full
        step("pp_clr", 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step("pp_fill", 1, 1, 0, 0);
        step("pp_both", 1, 1, 1, 0);
        check("pp.data", 32'(bus.rd_data), 32'd0);
        check("pp.drop", 32'(bus.drop_count), 32'd0);
        check("pp.full", 32'(bus.full), 32'd1);

        // Simultaneous push and pop while empty: push only
        step("pe_clr", 0, 0, 0, 1);
        step("pe_both", 1, 1, 1, 0);
        check("pe.rv", 32'(bus.rd_valid), 32'd0);
        check("pe.hit", 32'(bus.hit_count), 32'd1);

        // Timestamp wrap on the 4-bit copy
        step("wrap_clr", 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step("wrap_v", 1, 0, 0, 0);
        step("wrap_det", 0, 1, 0, 0);
        step("wrap_rd", 0, 0, 1, 0);
        check("wrap.data16", 32'(bus.rd_data), 32'd17);
        check("wrap.data4", 32'(bus4.rd_data), 32'd1);
        check("wrap.rv4", 32'(bus4.rd_valid), 32'd1);

        // clr and det together with two entries held
        step("cd_clr", 0, 0, 0, 1);
        step("cd_det", 1, 1, 0, 0);
        step("cd_det", 1, 1, 0, 0);
        step("cd_both", 1, 1, 0, 1);
        check("cd.empty", 32'(bus.empty), 32'd1);
        check("cd.hit", 32'(bus.hit_count), 32'd0);
        step("cd_after", 0, 0, 0, 0);
        check("cd.empty2", 32'(bus.empty), 32'd1);

        // Asynchronous reset between edges with three entries and a pending rd_valid
        step("ar_clr", 0, 0, 0, 1);
        step("ar_v", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("ar_det", 1, 1, 0, 0);
        step("ar_rd", 0, 0, 1, 0);
        check("ar.rv_before", 32'(bus.rd_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("ar.empty", 32'(bus.empty), 32'd1);
        check("ar.rdata", 32'(bus.rd_data), 32'd0);
        #1;
        rst = 1'b0;
        step("ar_rd_after", 0, 0, 1, 0);
        check("ar.no_rv", 32'(bus.rd_valid), 32'd0);

        // Random traffic: first half read-starved to exercise full/drop
        for (int i = 0; i < 3000; i++) begin
            bit v, d, r, c;
            v = ($urandom_range(0, 99) < 50);
            d = ($urandom_range(0, 99) < 40);
            r = ($urandom_range(0, 99) < ((i < 1500) ? 20 : 50));
            c = ($urandom_range(0, 299) == 0);
            step("rand", v, d, r, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_event_log.md
PATTERN_EVENT_LOG -- requirements
Module: pattern_event_log

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter TS_W, default 16, timestamp width.
REQ-003 SHALL have parameter CNT_W, default 16, hit/drop counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port valid_in  input  1  serial-bit strobe of the stream feeding the pattern detector.
REQ-007 SHALL have port det_in  input  1  one-cycle pattern_detected pulse from the detector.
REQ-008 SHALL have port rd_en  input  1  read request for the oldest logged event.
REQ-009 SHALL have port clr  input  1  synchronous clear of log, counters and flags.
REQ-010 SHALL have port rd_data  output  TS_W  timestamp of the popped event.
REQ-011 SHALL have port rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-012 SHALL have port empty  output  1  FIFO holds zero entries.
REQ-013 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-014 SHALL have port hit_count  output  CNT_W  detections accepted into the FIFO.
REQ-015 SHALL have port drop_count  output  CNT_W  detections lost to a full FIFO.
REQ-016 SHALL have port overflow  output  1  sticky flag, set on the first drop.

Function
REQ-017 SHALL keep a TS_W bit counter ts that increments by 1 on every cycle with valid_in=1, wrapping from all-ones to 0.
REQ-018 SHALL, on a cycle with det_in=1, push the registered ts value as sampled that cycle (pre-increment) into the FIFO.
REQ-019 SHALL complete a push in one cycle: count and empty/full update on the following edge.
REQ-020 SHALL, on a push with full=1 and no simultaneous pop, discard the event, increment drop_count and set overflow.
REQ-021 SHALL, on a push and pop in the same cycle while full, perform both with no drop and leave full=1.
REQ-022 SHALL, on a push and pop in the same cycle while empty, perform only the push; the pop is ignored.
REQ-023 SHALL, on rd_en=1 with empty=0, pop the oldest entry, drive it on rd_data and assert rd_valid for exactly one cycle on the next cycle (latency 1).
REQ-024 SHALL ignore rd_en while empty=1: no rd_valid, no pointer change, rd_data holds its last value.
REQ-025 SHALL implement the FIFO with read/write pointers of log2(DEPTH)+1 bits: empty when pointers are equal, full when the MSBs differ and the rest are equal.
REQ-026 SHALL increment hit_count per accepted push; hit_count and drop_count saturate at all-ones and never wrap.
REQ-027 SHALL keep overflow set until clr or rst.
REQ-028 SHALL, when clr=1, on the next edge zero ts, both pointers, hit_count, drop_count, overflow and rd_valid, with priority over push, pop and ts increment that cycle.
REQ-029 SHALL leave FIFO storage contents undefined after clr or rst; only pointers define occupancy.
REQ-030 SHALL contain no combinational path from any input to any output.

Reset
REQ-031 SHALL, on rst=1, immediately and without a clock set ts=0, pointers=0, hit_count=0, drop_count=0, overflow=0, rd_valid=0, rd_data=0, empty=1, full=0.
REQ-032 SHALL hold all state in reset while rst=1 and resume normal operation on the first rising edge after deassertion.
REQ-033 SHALL, on rst asserted mid-operation, discard all logged events and any pending rd_valid.

Verification
REQ-034 SHALL pass: 10 valid_in cycles, then det_in pulse, then rd_en -> next cycle rd_valid=1, rd_data=10, hit_count=1, empty=1.
REQ-035 SHALL pass: DEPTH=8, 9 det_in pulses, no reads -> full=1, hit_count=8, drop_count=1, overflow=1; 8 reads return the first 8 timestamps in order.
REQ-036 SHALL pass: FIFO full, det_in and rd_en in the same cycle -> drop_count unchanged, full stays 1, oldest entry returned.
REQ-037 SHALL pass: TS_W=4, 17 valid_in cycles then det_in -> logged timestamp 1 (wrap).
REQ-038 SHALL pass: 3 entries logged, rst pulsed asynchronously between edges -> outputs at reset values before the next edge, a following rd_en gives no rd_valid.
REQ-039 SHALL pass: clr and det_in in the same cycle with 2 entries held -> empty=1, hit_count=0, nothing pushed.
